// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: resolves load-use,
// taken-branch and multi-cycle data-memory hazards, and keeps stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int LU_BUBBLES  = 1,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_Rs,
  input  logic [4:0]       ifid_Rt,
  input  logic             id_uses_rt,
  input  logic             idex_MemRead,
  input  logic [4:0]       idex_WN,
  input  logic             exmem_MemRead,
  input  logic             exmem_MemWrite,
  input  logic [4:0]       exmem_WN,
  input  logic             branch_taken,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic             bubble_memwb,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TO_W = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t          state_r;
  state_t          stateNext_s;
  logic [TO_W-1:0] toCnt_r;

  logic memAcc_s;
  logic inWait_s;
  logic toExpire_s;
  logic memStall_s;
  logic lu1_s;
  logic lu2_s;
  logic lu_s;
  logic luActive_s;

  // A pending load whose destination feeds an operand the ID instruction reads.
  function automatic logic hazMatch(input logic isLoad, input logic [4:0] wn,
                                    input logic [4:0] rs, input logic [4:0] rt,
                                    input logic usesRt);
    hazMatch = isLoad & (wn != 5'd0) & ((wn == rs) | (usesRt & (wn == rt)));
  endfunction

  assign memAcc_s   = exmem_MemRead | exmem_MemWrite;
  assign inWait_s   = (state_r == MEM_WAIT);
  assign toExpire_s = inWait_s & (toCnt_r == TO_W'(MEM_TIMEOUT - 1));
  assign memStall_s = inWait_s ? ~(dmem_ready | toExpire_s) : (memAcc_s & ~dmem_ready);

  assign lu1_s = hazMatch(idex_MemRead, idex_WN, ifid_Rs, ifid_Rt, id_uses_rt);
  assign lu2_s = (LU_BUBBLES == 2) ? hazMatch(exmem_MemRead, exmem_WN, ifid_Rs, ifid_Rt, id_uses_rt)
                                   : 1'b0;
  assign lu_s  = lu1_s | lu2_s;
  // The retiring cycle of a wait only releases the freeze; hazards are re-judged next cycle.
  assign luActive_s = lu_s & ~inWait_s;

  // Next-state and pipeline-control decode, memory stall > load-use > branch.
  always_comb begin
    dmem_req     = 1'b0;
    en_pc        = 1'b0;
    en_ifid      = 1'b0;
    en_idex      = 1'b0;
    en_exmem     = 1'b0;
    en_memwb     = 1'b0;
    flush_ifid   = 1'b0;
    bubble_idex  = 1'b0;
    bubble_memwb = 1'b0;
    stateNext_s  = state_r;
    if (rst) begin
      stateNext_s = RUN;
    end else if (memStall_s) begin
      dmem_req     = 1'b1;
      en_memwb     = 1'b1;
      bubble_memwb = 1'b1;
      stateNext_s  = MEM_WAIT;
    end else if (luActive_s) begin
      dmem_req    = memAcc_s;
      en_idex     = 1'b1;
      en_exmem    = 1'b1;
      en_memwb    = 1'b1;
      bubble_idex = 1'b1;
      stateNext_s = RUN;
    end else begin
      dmem_req    = inWait_s | memAcc_s;
      en_pc       = 1'b1;
      en_ifid     = 1'b1;
      en_idex     = 1'b1;
      en_exmem    = 1'b1;
      en_memwb    = 1'b1;
      flush_ifid  = branch_taken & ~lu_s;
      stateNext_s = RUN;
    end
  end

  // State, timeout counter, sticky error and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RUN;
      toCnt_r   <= {TO_W{1'b0}};
      mem_err   <= 1'b0;
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      state_r <= stateNext_s;
      if (inWait_s && (stateNext_s == MEM_WAIT)) begin
        toCnt_r <= toCnt_r + TO_W'(1);
      end else begin
        toCnt_r <= {TO_W{1'b0}};
      end
      mem_err <= mem_err | (toExpire_s & ~dmem_ready);
      if (!en_pc && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (flush_ifid && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus saturation sequences,
// expectations queued as stimulus is driven and compared when outputs settle.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] ifid_Rs, ifid_Rt, idex_WN, exmem_WN;
  logic       id_uses_rt, idex_MemRead, exmem_MemRead, exmem_MemWrite;
  logic       branch_taken, dmem_ready;
  logic       dmem_req, en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic       flush_ifid, bubble_idex, bubble_memwb, mem_err;
  logic [3:0] stall_cnt, flush_cnt;

  // {dmem_req, en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, bubble_idex, bubble_memwb}
  localparam logic [8:0] O_R  = 9'b000000000;
  localparam logic [8:0] O_N  = 9'b011111000;
  localparam logic [8:0] O_LU = 9'b000111010;
  localparam logic [8:0] O_BR = 9'b011111100;
  localparam logic [8:0] O_MS = 9'b100001001;
  localparam logic [8:0] O_MR = 9'b111111000;

  typedef struct {
    logic       r;
    logic [4:0] rs, rt;
    logic       ur, ird;
    logic [4:0] iwn;
    logic       erd, ewr;
    logic [4:0] ewn;
    logic       br, rdy;
    logic [8:0] out;
    logic [3:0] sc, fc;
    logic       er;
  } vec_t;

  typedef struct {
    int         tag;
    logic [8:0] out;
    logic [3:0] sc, fc;
    logic       er;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  pipe_hazard_ctrl #(.LU_BUBBLES(1), .MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .ifid_Rs(ifid_Rs), .ifid_Rt(ifid_Rt), .id_uses_rt(id_uses_rt),
    .idex_MemRead(idex_MemRead), .idex_WN(idex_WN),
    .exmem_MemRead(exmem_MemRead), .exmem_MemWrite(exmem_MemWrite), .exmem_WN(exmem_WN),
    .branch_taken(branch_taken), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex),
    .en_exmem(en_exmem), .en_memwb(en_memwb), .flush_ifid(flush_ifid),
    .bubble_idex(bubble_idex), .bubble_memwb(bubble_memwb), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                              input logic ur, input logic ird, input logic [4:0] iwn,
                              input logic erd, input logic ewr, input logic [4:0] ewn,
                              input logic br, input logic rdy, input logic [8:0] out,
                              input logic [3:0] sc, input logic [3:0] fc, input logic er);
    vec_t v;
    v.r = r; v.rs = rs; v.rt = rt; v.ur = ur; v.ird = ird; v.iwn = iwn;
    v.erd = erd; v.ewr = ewr; v.ewn = ewn; v.br = br; v.rdy = rdy;
    v.out = out; v.sc = sc; v.fc = fc; v.er = er;
    return v;
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h, expected %0h", nm, tag, act, exp);
    end
  endtask

  task automatic checkOut();
    exp_t e;
    logic [8:0] act;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e   = sbq.pop_front();
      act = {dmem_req, en_pc, en_ifid, en_idex, en_exmem, en_memwb,
             flush_ifid, bubble_idex, bubble_memwb};
      chk("ctrl", e.tag, 32'(act), 32'(e.out));
      chk("stall_cnt", e.tag, 32'(stall_cnt), 32'(e.sc));
      chk("flush_cnt", e.tag, 32'(flush_cnt), 32'(e.fc));
      chk("mem_err", e.tag, 32'(mem_err), 32'(e.er));
    end
  endtask

  task automatic runCycle(input vec_t v, input int tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = v.r; ifid_Rs = v.rs; ifid_Rt = v.rt; id_uses_rt = v.ur;
    idex_MemRead = v.ird; idex_WN = v.iwn;
    exmem_MemRead = v.erd; exmem_MemWrite = v.ewr; exmem_WN = v.ewn;
    branch_taken = v.br; dmem_ready = v.rdy;
    e.tag = tag; e.out = v.out; e.sc = v.sc; e.fc = v.fc; e.er = v.er;
    sbq.push_back(e);
    @(negedge clk);
    checkOut();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] msc;
    logic [3:0] mfc;
    rst = 1'b1; ifid_Rs = 5'd0; ifid_Rt = 5'd0; id_uses_rt = 1'b0;
    idex_MemRead = 1'b0; idex_WN = 5'd0; exmem_MemRead = 1'b0;
    exmem_MemWrite = 1'b0; exmem_WN = 5'd0; branch_taken = 1'b0; dmem_ready = 1'b0;

    //              r  rs     rt     ur ird iwn   erd ewr ewn   br rdy out   sc     fc     er
    tbl.push_back(mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, O_R,  4'd0,  4'd0, 0)); // reset
    tbl.push_back(mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, O_R,  4'd0,  4'd0, 0));
    tbl.push_back(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0, O_N,  4'd0,  4'd0, 0)); // normal
    tbl.push_back(mk(0, 5'd5, 5'd2, 1, 1, 5'd5, 0, 0, 5'd0, 0, 0, O_LU, 4'd0,  4'd0, 0)); // lu on rs
    tbl.push_back(mk(0, 5'd5, 5'd2, 1, 0, 5'd5, 0, 0, 5'd0, 0, 0, O_N,  4'd1,  4'd0, 0));
    tbl.push_back(mk(0, 5'd0, 5'd2, 1, 1, 5'd0, 0, 0, 5'd0, 0, 0, O_N,  4'd1,  4'd0, 0)); // $zero
    tbl.push_back(mk(0, 5'd3, 5'd7, 0, 1, 5'd7, 0, 0, 5'd0, 0, 0, O_N,  4'd1,  4'd0, 0)); // rt unused
    tbl.push_back(mk(0, 5'd3, 5'd7, 1, 1, 5'd7, 0, 0, 5'd0, 0, 0, O_LU, 4'd1,  4'd0, 0)); // lu on rt
    tbl.push_back(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 5'd0, 1, 0, O_BR, 4'd2,  4'd0, 0)); // branch
    tbl.push_back(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0, O_N,  4'd2,  4'd1, 0));
    tbl.push_back(mk(0, 5'd5, 5'd2, 1, 1, 5'd5, 0, 0, 5'd0, 1, 0, O_LU, 4'd2,  4'd1, 0)); // branch+lu
    tbl.push_back(mk(0, 5'd4, 5'd2, 1, 0, 5'd0, 1, 0, 5'd4, 0, 1, O_MR, 4'd3,  4'd1, 0)); // zero-wait, no lu2
    tbl.push_back(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, 5'd9, 0, 0, O_MS, 4'd3,  4'd1, 0)); // mem wait
    tbl.push_back(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, 5'd9, 0, 0, O_MS, 4'd4,  4'd1, 0));
    tbl.push_back(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, 5'd9, 0, 0, O_MS, 4'd5,  4'd1, 0));
    tbl.push_back(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, 5'd9, 0, 1, O_MR, 4'd6,  4'd1, 0));
    tbl.push_back(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0, O_N,  4'd6,  4'd1, 0));
    tbl.push_back(mk(0, 5'd5, 5'd2, 1, 1, 5'd5, 1, 0, 5'd9, 0, 0, O_MS, 4'd6,  4'd1, 0)); // priority
    tbl.push_back(mk(0, 5'd5, 5'd2, 1, 1, 5'd5, 1, 0, 5'd9, 0, 0, O_MS, 4'd7,  4'd1, 0));
    tbl.push_back(mk(0, 5'd5, 5'd2, 1, 1, 5'd5, 1, 0, 5'd9, 0, 1, O_MR, 4'd8,  4'd1, 0));
    tbl.push_back(mk(0, 5'd5, 5'd2, 1, 1, 5'd5, 0, 0, 5'd0, 0, 0, O_LU, 4'd8,  4'd1, 0));
    tbl.push_back(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0, O_N,  4'd9,  4'd1, 0));
    tbl.push_back(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 5'd0, 0, 0, O_MS, 4'd9,  4'd1, 0)); // timeout
    tbl.push_back(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 5'd0, 0, 0, O_MS, 4'd10, 4'd1, 0));
    tbl.push_back(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 5'd0, 0, 0, O_MS, 4'd11, 4'd1, 0));
    tbl.push_back(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 5'd0, 0, 0, O_MS, 4'd12, 4'd1, 0));
    tbl.push_back(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 5'd0, 0, 0, O_MR, 4'd13, 4'd1, 0));
    tbl.push_back(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0, O_N,  4'd13, 4'd1, 1));
    tbl.push_back(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0, O_N,  4'd13, 4'd1, 1)); // sticky
    tbl.push_back(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, 5'd9, 0, 0, O_MS, 4'd13, 4'd1, 1)); // reset mid-wait
    tbl.push_back(mk(1, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, 5'd9, 0, 0, O_R,  4'd14, 4'd1, 1));
    tbl.push_back(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0, O_N,  4'd0,  4'd0, 0)); // back in RUN

    for (int i = 0; i < tbl.size(); i++) begin
      runCycle(tbl[i], i);
    end

    // Saturation of stall_cnt under a continuous load-use stall.
    msc = 4'd0;
    mfc = 4'd0;
    for (int k = 0; k < 18; k++) begin
      runCycle(mk(0, 5'd5, 5'd2, 1, 1, 5'd5, 0, 0, 5'd0, 0, 0, O_LU, msc, mfc, 0), 100 + k);
      if (msc != 4'hF) msc = msc + 4'd1;
    end
    // Saturation of flush_cnt under back-to-back taken branches.
    for (int k = 0; k < 18; k++) begin
      runCycle(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 5'd0, 1, 0, O_BR, msc, mfc, 0), 200 + k);
      if (mfc != 4'hF) mfc = mfc + 4'd1;
    end
    runCycle(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0, O_N, msc, mfc, 0), 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It generates the enable and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves three hazard sources:
- load-use data hazards;
- taken-branch flushes;
- multi-cycle data-memory accesses, via a req/ready handshake with a timeout.
It also keeps stall and flush performance counters.

Parameters:
LU_BUBBLES, 1, load-use bubbles required: 1 = MEM->EX forwarding exists; 2 = no MEM forwarding.
MEM_TIMEOUT, 64, max MEM_WAIT cycles before forced completion (must be >= 2).
CNT_W, 16, width of performance counters.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
ifid_Rs  in  5  rs field of instruction in ID
ifid_Rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
idex_MemRead  in  1  instruction in EX is a load
idex_WN  in  5  destination register of EX instruction
exmem_MemRead  in  1  instruction in MEM is a load
exmem_MemWrite  in  1  instruction in MEM is a store
exmem_WN  in  5  destination register of MEM instruction
branch_taken  in  1  branch resolved taken in ID
dmem_ready  in  1  data memory completes access this cycle
dmem_req  out  1  data memory access request
en_pc  out  1  PC write enable
en_ifid  out  1  IF/ID enReg
en_idex  out  1  ID/EX enReg
en_exmem  out  1  EX/MEM enReg
en_memwb  out  1  MEM/WB enReg
flush_ifid  out  1  load NOP into IF/ID
bubble_idex  out  1  zero ID/EX control bits (RegWrite/MemRead/MemWrite/MemtoReg)
bubble_memwb  out  1  zero MEM/WB RegWrite/MemtoReg
mem_err  out  1  sticky: a MEM_TIMEOUT expiry occurred
stall_cnt  out  CNT_W  cycles with en_pc=0
flush_cnt  out  CNT_W  IF/ID flushes issued

Behaviour:
- Reset: clk/rst as above; rst synchronous, active-high.
  - State <= RUN; timeout counter, stall_cnt, flush_cnt, mem_err <= 0.
  - While rst=1: all en_* = 0, dmem_req = 0, flush/bubble = 0.
- Definitions:
  - mem_acc = exmem_MemRead | exmem_MemWrite.
  - lu1 = idex_MemRead & idex_WN!=0 & (idex_WN==ifid_Rs | (id_uses_rt & idex_WN==ifid_Rt)).
  - lu2 = same test using exmem_MemRead/exmem_WN; counts only when LU_BUBBLES==2.
  - lu = lu1 | lu2.
- FSM states: RUN, MEM_WAIT. All outputs are combinational from state and inputs; zero added latency.
- dmem_req = mem_acc in RUN, and 1 in MEM_WAIT. Once raised, it holds until the dmem_ready cycle.
- Memory stall (highest priority):
  - Condition: RUN & mem_acc & !dmem_ready, or MEM_WAIT & !dmem_ready.
  - Response: en_pc = en_ifid = en_idex = en_exmem = 0; en_memwb = 1 with bubble_memwb = 1.
  - RUN -> MEM_WAIT on the first such cycle.
  - In MEM_WAIT on dmem_ready: -> RUN, all enables = 1 that cycle (access retires into MEM/WB).
  - dmem_ready in the request cycle: zero-wait, no stall, stay in RUN.
- Timeout:
  - Counter increments each MEM_WAIT cycle.
  - On reaching MEM_TIMEOUT-1 without ready: treat as ready (advance, -> RUN), set mem_err = 1 (sticky until rst).
  - Counter clears on entering RUN.
- Load-use stall (only when no memory stall):
  - en_pc = en_ifid = 0.
  - en_idex = 1 with bubble_idex = 1.
  - en_exmem = en_memwb = 1.
  - branch_taken is ignored during the stall; the ID operands are invalid.
- Branch flush (only when no memory stall and no lu): flush_ifid = 1; all enables = 1; flush_cnt += 1.
- Normal operation: all enables = 1, all flush/bubble = 0.
- Counters:
  - stall_cnt += 1 on each non-reset cycle with en_pc = 0.
  - Both counters saturate at all-ones; they do not wrap.
- Reset mid-MEM_WAIT: immediate return to RUN; dmem_req drops the same cycle.

Test Plan:
- Load-use: idex_MemRead=1, idex_WN=5, ifid_Rs=5, LU_BUBBLES=1 -> one cycle of en_pc=0, en_ifid=0, bubble_idex=1, then normal; stall_cnt=1.
- $zero and unused-rt cases:
  - idex_WN=0 matching Rs -> no stall.
  - idex_WN=7 == ifid_Rt with id_uses_rt=0 -> no stall.
- Branch: branch_taken=1, no hazard -> flush_ifid=1 for 1 cycle, flush_cnt=1. Same with lu=1 -> stall only, flush_cnt unchanged.
- Memory wait: exmem_MemRead=1, dmem_ready low 3 cycles then high ->
  - dmem_req high 4 cycles;
  - first 3 cycles: front enables 0 and bubble_memwb=1;
  - ready cycle: all enables 1;
  - stall_cnt=3.
- Priority: lu1 and a memory stall asserted together -> memory freeze only (bubble_idex=0) until ready, then the load-use bubble is applied the next cycle.
- Timeout and reset:
  - MEM_TIMEOUT=4, dmem_ready held 0 -> forced advance after 4 cycles, mem_err=1 sticky.
  - Assert rst during MEM_WAIT -> dmem_req=0, mem_err=0, state RUN next cycle.
